reg_request_encoder: RTL and testbench



---
 rtl/reg_request_encoder.sv | 126 ++++++++++++
 tb/tb_reg_request_encoder.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_request_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : reg_request_encoder
//  Purpose  : Round-robin arbiter/encoder. Collapses up to 16 concurrent
//             register-write requests into one 5-bit register select per
//             transfer. It feeds the select input of the 5-to-16 register
//             enable decoder, where codes 5'h10-5'h1F mean "no enable".
//  Ports    : clk       - rising-edge clock
//             reset_n   - asynchronous active-low reset
//             req       - [15:0] request lines, bit i requests register i
//             sel_out   - [4:0] granted index, or IDLE_CODE when no grant
//             sel_valid - a grant is being offered on sel_out
//             sel_ready - downstream accepts the offered grant this cycle
//  Params   : IDLE_CODE - code driven on sel_out while idle (>= 5'h10)
//  Revision : 1.0 - initial release
// ============================================================================
module reg_request_encoder #(
    parameter logic [4:0] IDLE_CODE = 5'h1F
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] req,
    output logic [4:0]  sel_out,
    output logic        sel_valid,
    input  logic        sel_ready
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic [3:0]  r_ptr;
    logic [3:0]  w_ptrNext;
    logic [4:0]  r_selOut;
    logic [4:0]  w_selOutNext;
    logic        r_selValid;
    logic        w_selValidNext;

    // Arbitration signals
    logic [3:0]  w_base;
    logic [3:0]  w_idx;
    logic [3:0]  w_winner;
    logic        w_found;
    logic        w_accept;

    assign w_accept = r_selValid & sel_ready;

    // On acceptance the search restarts just above the granted index, so the
    // pointer update and the re-arbitration happen in the same cycle.
    assign w_base = w_accept ? (r_selOut[3:0] + 4'd1) : r_ptr;

    // First set bit of req searching upward from w_base, wrapping 15 -> 0.
    always_comb begin
        w_found  = 1'b0;
        w_winner = 4'd0;
        w_idx    = 4'd0;
        for (int i = 0; i < 16; i++) begin
            w_idx = w_base + 4'(i);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_stateNext    = r_state;
        w_ptrNext      = r_ptr;
        w_selOutNext   = r_selOut;
        w_selValidNext = r_selValid;
        case (r_state)
            ST_IDLE: begin
                w_selOutNext   = IDLE_CODE;
                w_selValidNext = 1'b0;
                if (w_found) begin
                    w_selOutNext   = {1'b0, w_winner};
                    w_selValidNext = 1'b1;
                    w_stateNext    = ST_OFFER;
                end
            end
            ST_OFFER: begin
                // An offered grant stands regardless of req until accepted.
                if (w_accept) begin
                    w_ptrNext = w_base;
                    if (w_found) begin
                        w_selOutNext   = {1'b0, w_winner};
                        w_selValidNext = 1'b1;
                        w_stateNext    = ST_OFFER;
                    end else begin
                        w_selOutNext   = IDLE_CODE;
                        w_selValidNext = 1'b0;
                        w_stateNext    = ST_IDLE;
                    end
                end
            end
            default: begin
                w_stateNext    = ST_IDLE;
                w_selOutNext   = IDLE_CODE;
                w_selValidNext = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_ptr      <= 4'd0;
            r_selOut   <= IDLE_CODE;
            r_selValid <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_ptr      <= w_ptrNext;
            r_selOut   <= w_selOutNext;
            r_selValid <= w_selValidNext;
        end
    end

    assign sel_out   = r_selOut;
    assign sel_valid = r_selValid;

endmodule
`default_nettype wire

// File: tb/tb_reg_request_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_request_encoder
//  Purpose  : Self-checking bench for reg_request_encoder. Expected grants
//             are queued when stimulus is driven; a monitor queues every
//             accepted grant and each scenario compares the two queues.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_request_encoder;

    logic        clk;
    logic        reset_n;
    logic [15:0] req;
    logic [4:0]  sel_out;
    logic        sel_valid;
    logic        sel_ready;

    int checks;
    int errors;

    logic [4:0] expQ[$];
    logic [4:0] obsQ[$];

    reg_request_encoder #(.IDLE_CODE(5'h1F)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .sel_out   (sel_out),
        .sel_valid (sel_valid),
        .sel_ready (sel_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs only change 1 time unit after a rising edge, so at the falling
    // edge a valid&&ready pair means the next rising edge accepts sel_out.
    always @(negedge clk) begin
        if (reset_n && sel_valid && sel_ready)
            obsQ.push_back(sel_out);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req       = 16'h0000;
        sel_ready = 1'b0;
        tick();
        tick();
        expQ.delete();
        obsQ.delete();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [4:0] e;
        logic [4:0] o;
        reset_n   = 1'b0;
        req       = 16'hFFFF;
        sel_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (sel_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_valid got %b want 0", sel_valid);
            end
            checks++;
            if (sel_out !== 5'h1F) begin
                errors++;
                $display("FAIL reset_sel got %h want 1f", sel_out);
            end
        end
        // Asynchronous reset in the middle of an offer
        do_reset();
        req       = 16'h0001;
        sel_ready = 1'b0;
        tick();
        checks++;
        if (sel_valid !== 1'b1 || sel_out !== 5'h00) begin
            errors++;
            $display("FAIL reset_preoffer got v=%b sel=%h want v=1 sel=00", sel_valid, sel_out);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (sel_valid !== 1'b0 || sel_out !== 5'h1F) begin
            errors++;
            $display("FAIL reset_async got v=%b sel=%h want v=0 sel=1f", sel_valid, sel_out);
        end
        tick();
        reset_n = 1'b1;
        req     = 16'h0000;
        tick();
        checks++;
        if (obsQ.size() != 0) begin
            errors++;
            $display("FAIL reset_grants got %0d want 0", obsQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
        end
    endtask

    task automatic test_single();
        logic [4:0] e;
        logic [4:0] o;
        do_reset();
        req       = 16'h0001;
        sel_ready = 1'b1;
        expQ.push_back(5'h00);
        tick();
        req = 16'h0000;
        checks++;
        if (sel_valid !== 1'b1 || sel_out !== 5'h00) begin
            errors++;
            $display("FAIL single_grant got v=%b sel=%h want v=1 sel=00", sel_valid, sel_out);
        end
        tick();
        checks++;
        if (sel_valid !== 1'b0 || sel_out !== 5'h1F) begin
            errors++;
            $display("FAIL single_idle got v=%b sel=%h want v=0 sel=1f", sel_valid, sel_out);
        end
        checks++;
        if (obsQ.size() != expQ.size()) begin
            errors++;
            $display("FAIL single_count got %0d want %0d", obsQ.size(), expQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL single_sb got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_alternation();
        logic [4:0] e;
        logic [4:0] o;
        do_reset();
        req       = 16'h8001;
        sel_ready = 1'b1;
        expQ.push_back(5'h00);
        expQ.push_back(5'h0F);
        expQ.push_back(5'h00);
        expQ.push_back(5'h0F);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (sel_valid !== 1'b1) begin
                errors++;
                $display("FAIL alt_bubble cycle %0d got v=%b want 1", i, sel_valid);
            end
        end
        req = 16'h0000;
        tick();
        checks++;
        if (sel_valid !== 1'b0) begin
            errors++;
            $display("FAIL alt_idle got v=%b want 0", sel_valid);
        end
        checks++;
        if (obsQ.size() != expQ.size()) begin
            errors++;
            $display("FAIL alt_count got %0d want %0d", obsQ.size(), expQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL alt_sb got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [4:0] e;
        logic [4:0] o;
        do_reset();
        req       = 16'h0010;
        sel_ready = 1'b0;
        expQ.push_back(5'h04);
        tick();
        req = 16'h0100;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (sel_valid !== 1'b1 || sel_out !== 5'h04) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got v=%b sel=%h want v=1 sel=04", i, sel_valid, sel_out);
            end
        end
        sel_ready = 1'b1;
        expQ.push_back(5'h08);
        tick();
        checks++;
        if (sel_valid !== 1'b1 || sel_out !== 5'h08) begin
            errors++;
            $display("FAIL bp_next got v=%b sel=%h want v=1 sel=08", sel_valid, sel_out);
        end
        req = 16'h0000;
        tick();
        checks++;
        if (obsQ.size() != expQ.size()) begin
            errors++;
            $display("FAIL bp_count got %0d want %0d", obsQ.size(), expQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL bp_sb got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_wrap();
        logic [4:0] e;
        logic [4:0] o;
        do_reset();
        req       = 16'h4000;
        sel_ready = 1'b0;
        expQ.push_back(5'h0E);
        tick();
        req       = 16'h0003;
        sel_ready = 1'b1;
        expQ.push_back(5'h00);
        expQ.push_back(5'h01);
        tick();
        tick();
        req = 16'h0000;
        tick();
        checks++;
        if (sel_valid !== 1'b0 || sel_out !== 5'h1F) begin
            errors++;
            $display("FAIL wrap_idle got v=%b sel=%h want v=0 sel=1f", sel_valid, sel_out);
        end
        checks++;
        if (obsQ.size() != expQ.size()) begin
            errors++;
            $display("FAIL wrap_count got %0d want %0d", obsQ.size(), expQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL wrap_sb got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] e;
        logic [4:0] o;
        do_reset();
        req       = 16'hFFFF;
        sel_ready = 1'b1;
        for (int i = 0; i < 32; i++)
            expQ.push_back(5'(i % 16));
        for (int i = 0; i < 32; i++) begin
            tick();
            checks++;
            if (sel_valid !== 1'b1 || sel_out[4] !== 1'b0) begin
                errors++;
                $display("FAIL b2b_valid cycle %0d got v=%b sel=%h want v=1 sel<10", i, sel_valid, sel_out);
            end
        end
        req = 16'h0000;
        tick();
        checks++;
        if (obsQ.size() != expQ.size()) begin
            errors++;
            $display("FAIL b2b_count got %0d want %0d", obsQ.size(), expQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL b2b_sb got %h want %h", o, e);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        req       = 16'h0000;
        sel_ready = 1'b0;
        test_reset();
        test_single();
        test_alternation();
        test_backpressure();
        test_wrap();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
